// File: rtl/range_pkg.sv
// Shared types and widths for the range scan controller.
package range_pkg;

    localparam int RAM_WORDS_DEF     = 256;
    localparam int RAM_ADDR_BITS_DEF = 8;
    localparam int CNT_W             = 16;
    localparam int START_W           = 32;
    localparam int N_W               = 22;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        SCAN,
        DRAIN,
        DONE
    } scan_state_t;

endpackage

// File: rtl/scan_max_tracker.sv
// Aligns returned counts with their read addresses and keeps the running max.
// The first returned word of a scan always loads, so an all-zero range reports
// max_n = base; later words replace it only when strictly greater, so ties keep
// the lowest address.
module scan_max_tracker
    import range_pkg::*;
#(
    parameter int ADDR_BITS = RAM_ADDR_BITS_DEF,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 issue,
    input  logic [ADDR_BITS-1:0] issue_addr,
    input  logic [N_W-1:0]       base,
    input  logic [CNT_W-1:0]     rng_count,
    output logic [CNT_W-1:0]     max_count,
    output logic [N_W-1:0]       max_n
);

    logic [RD_LAT-1:0]                vld_q;
    logic [RD_LAT-1:0][ADDR_BITS-1:0] tag_q;
    logic                             first_q;
    logic [CNT_W-1:0]                 max_count_q;
    logic [N_W-1:0]                   max_n_q;
    logic                             hit;

    assign hit       = vld_q[RD_LAT-1] && (first_q || (rng_count > max_count_q));
    assign max_count = max_count_q;
    assign max_n     = max_n_q;

    // Tag pipe shift and max update; clear also flushes anything in flight.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            vld_q       <= '0;
            tag_q       <= '0;
            first_q     <= 1'b1;
            max_count_q <= '0;
            max_n_q     <= '0;
        end else begin
            vld_q[0] <= issue;
            tag_q[0] <= issue_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
            if (hit) begin
                first_q     <= 1'b0;
                max_count_q <= rng_count;
                max_n_q     <= base + N_W'(tag_q[RD_LAT-1]);
            end
        end
    end

endmodule

// File: rtl/range_scan_ctrl.sv
// Range scan controller: launches the range unit, waits for completion, then
// walks every result word and reports the largest count and its n.
// Optional feature macro: SCAN_TIMEOUT_EN bounds the WAIT state by TIMEOUT
// cycles and reports expiry on error.
module range_scan_ctrl
    import range_pkg::*;
#(
    parameter int RAM_WORDS     = RAM_WORDS_DEF,
    parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
    parameter int RD_LAT        = 1,
    parameter int TIMEOUT       = 50_000_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     scan_req,
    input  logic [N_W-1:0]           base,
    input  logic [RAM_ADDR_BITS-1:0] user_addr,
    output logic                     rng_go,
    output logic [START_W-1:0]       rng_start,
    input  logic                     rng_done,
    input  logic [CNT_W-1:0]         rng_count,
    output logic                     busy,
    output logic                     result_valid,
    output logic [CNT_W-1:0]         max_count,
    output logic [N_W-1:0]           max_n,
    output logic                     error
);

    scan_state_t              state_q, state_d;
    logic [N_W-1:0]           base_q, base_d;
    logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [2:0]               drain_q, drain_d;
    logic                     rv_q, rv_d;
    logic                     clear;
    logic                     issue;

`ifdef SCAN_TIMEOUT_EN
    logic [31:0]              tmo_q, tmo_d;
    logic                     err_q, err_d;
`endif

    // Next state, datapath controls and port arbitration.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        rv_d    = rv_q;
        clear   = 1'b0;
`ifdef SCAN_TIMEOUT_EN
        err_d   = err_q;
        tmo_d   = '0;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (scan_req) begin
                    state_d = LAUNCH;
                    base_d  = base;
                    rv_d    = 1'b0;
                    clear   = 1'b1;
`ifdef SCAN_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                if (rng_done) begin
                    state_d = SCAN;
                    addr_d  = '0;
                end
`ifdef SCAN_TIMEOUT_EN
                else if (tmo_q == 32'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
`endif
            end
            SCAN: begin
                if (addr_q == RAM_ADDR_BITS'(RAM_WORDS - 1)) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                // Last read returns during the RD_LAT-th drain cycle.
                if (drain_q == 3'(RD_LAT - 1)) begin
                    state_d = DONE;
                    rv_d    = 1'b1;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        rng_go = (state_q == LAUNCH);
        busy   = (state_q == LAUNCH) || (state_q == WAIT) ||
                 (state_q == SCAN)   || (state_q == DRAIN);
        issue  = (state_q == SCAN);
        case (state_q)
            IDLE, DONE:   rng_start = START_W'(user_addr);
            LAUNCH, WAIT: rng_start = START_W'(base_q);
            default:      rng_start = START_W'(addr_q);
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            drain_q <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            rv_q    <= rv_d;
        end
    end

`ifdef SCAN_TIMEOUT_EN
    // WAIT cycle counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    assign result_valid = rv_q;

    scan_max_tracker #(
        .ADDR_BITS (RAM_ADDR_BITS),
        .RD_LAT    (RD_LAT)
    ) u_tracker (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .issue      (issue),
        .issue_addr (addr_q),
        .base       (base_q),
        .rng_count  (rng_count),
        .max_count  (max_count),
        .max_n      (max_n)
    );

endmodule

// File: tb/tb_range_scan_ctrl.sv
// Scoreboard bench: two controllers (RD_LAT=1 and RD_LAT=3) share stimulus and a
// behavioural range unit; expected results are queued at issue and checked when
// each controller raises result_valid or pulses rng_go.
module tb_range_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scan_req = 1'b0;
    logic [21:0] base = '0;
    logic [7:0]  user_addr = '0;
    logic        done = 1'b0;

    logic        go1, go3, busy1, busy3, rv1, rv3, err1, err3;
    logic [31:0] st1, st3;
    logic [15:0] rc1 = '0;
    logic [15:0] rc3;
    logic [15:0] mc1, mc3;
    logic [21:0] mn1, mn3;

    always #5 clk = ~clk;

    range_scan_ctrl #(.RAM_WORDS(256), .RAM_ADDR_BITS(8), .RD_LAT(1), .TIMEOUT(1000)) dut1 (
        .clk(clk), .reset(reset), .scan_req(scan_req), .base(base), .user_addr(user_addr),
        .rng_go(go1), .rng_start(st1), .rng_done(done), .rng_count(rc1),
        .busy(busy1), .result_valid(rv1), .max_count(mc1), .max_n(mn1), .error(err1));

    range_scan_ctrl #(.RAM_WORDS(256), .RAM_ADDR_BITS(8), .RD_LAT(3), .TIMEOUT(1000)) dut3 (
        .clk(clk), .reset(reset), .scan_req(scan_req), .base(base), .user_addr(user_addr),
        .rng_go(go3), .rng_start(st3), .rng_done(done), .rng_count(rc3),
        .busy(busy3), .result_valid(rv3), .max_count(mc3), .max_n(mn3), .error(err3));

    // ---------------- behavioural range unit ----------------
    logic [15:0] mem [256];
    logic [15:0] p3 [3];
    int          tmr = 0;
    bit          never_done = 1'b0;

    always @(posedge clk) begin
        done <= 1'b0;
        if (reset) tmr <= 0;
        else if (go1) tmr <= 20;
        else if (tmr > 0) begin
            tmr <= tmr - 1;
            if (tmr == 1 && !never_done) done <= 1'b1;
        end
    end

    always @(posedge clk) begin
        rc1   <= mem[st1[7:0]];
        p3[0] <= mem[st3[7:0]];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rc3 = p3[2];

    // ---------------- scoreboard ----------------
    typedef struct { logic [15:0] cnt; logic [21:0] n; } res_t;
    res_t        q1[$], q3[$], e1, e3;
    logic [31:0] lq1[$], lq3[$];
    int          go_cnt1 = 0, go_cnt3 = 0, exp_go = 0;
    int          n_chk = 0, n_pass = 0;
    logic        rv1_prev = 1'b0, rv3_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rv1 && !rv1_prev) begin
            if (q1.size() == 0) chk("rv_unexpected_l1", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                chk("max_count_l1", 32'(mc1), 32'(e1.cnt));
                chk("max_n_l1", 32'(mn1), 32'(e1.n));
            end
        end
        if (rv3 && !rv3_prev) begin
            if (q3.size() == 0) chk("rv_unexpected_l3", 32'd1, 32'd0);
            else begin
                e3 = q3.pop_front();
                chk("max_count_l3", 32'(mc3), 32'(e3.cnt));
                chk("max_n_l3", 32'(mn3), 32'(e3.n));
            end
        end
        rv1_prev <= rv1;
        rv3_prev <= rv3;
        if (go1) begin
            go_cnt1++;
            if (lq1.size() == 0) chk("go_unexpected_l1", 32'd1, 32'd0);
            else chk("launch_start_l1", st1, lq1.pop_front());
        end
        if (go3) begin
            go_cnt3++;
            if (lq3.size() == 0) chk("go_unexpected_l3", 32'd1, 32'd0);
            else chk("launch_start_l3", st3, lq3.pop_front());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_launch(input logic [21:0] b);
        lq1.push_back({10'b0, b});
        lq3.push_back({10'b0, b});
        exp_go++;
    endtask

    task automatic run_scan(input logic [21:0] b, input logic [15:0] ec,
                            input logic [21:0] en, input bit toggle);
        res_t e;
        int   k;
        e.cnt = ec;
        e.n   = en;
        q1.push_back(e);
        q3.push_back(e);
        push_launch(b);
        base     = b;
        scan_req = 1'b1;
        @(negedge clk);
        scan_req = 1'b0;
        k = 0;
        while (!(rv1 && rv3) && k < 3000) begin
            if (toggle) user_addr = 8'($urandom);
            @(negedge clk);
            k++;
        end
        if (!(rv1 && rv3)) chk("scan_completion_timeout", 32'd0, 32'd1);
        chk("go_count_l1", 32'(go_cnt1), 32'(exp_go));
        chk("go_count_l3", 32'(go_cnt3), 32'(exp_go));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy1), 32'd0);
        chk({tag, "_rv"}, 32'(rv1), 32'd0);
        chk({tag, "_max_count"}, 32'(mc1), 32'd0);
        chk({tag, "_max_n"}, 32'(mn1), 32'd0);
        chk({tag, "_error"}, 32'(err1), 32'd0);
        chk({tag, "_go"}, 32'(go1), 32'd0);
        chk({tag, "_busy_l3"}, 32'(busy3), 32'd0);
        chk({tag, "_max_count_l3"}, 32'(mc3), 32'd0);
        chk({tag, "_max_n_l3"}, 32'(mn3), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        for (int a = 0; a < 256; a++) mem[a] = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        // user address owns the read port while idle
        user_addr = 8'h33;
        @(negedge clk);
        chk("idle_user_addr_l1", st1, 32'h33);
        chk("idle_user_addr_l3", st3, 32'h33);

        // count[a] = a ^ 5A: unique max 0xFF at 0xA5; user_addr toggles during scan
        for (int a = 0; a < 256; a++) mem[a] = 16'(a ^ 8'h5A);
        run_scan(22'd100, 16'h00FF, 22'd100 + 22'hA5, 1'b1);
        user_addr = 8'h33;
        @(negedge clk);
        chk("done_user_addr_l1", st1, 32'h33);
        chk("done_user_addr_l3", st3, 32'h33);
        chk("done_busy", 32'(busy1), 32'd0);

        // all equal counts: lowest address wins
        for (int a = 0; a < 256; a++) mem[a] = 16'd7;
        run_scan(22'd50, 16'd7, 22'd50, 1'b0);

        // n wraps at 22 bits
        for (int a = 0; a < 256; a++) mem[a] = 16'd1;
        mem[8'h20] = 16'd9;
        run_scan(22'h3FFFF0, 16'd9, 22'h000010, 1'b0);

        // reset mid-scan at address 0x40, then a clean rerun
        for (int a = 0; a < 256; a++) mem[a] = 16'(a ^ 8'h5A);
        push_launch(22'd200);
        base     = 22'd200;
        scan_req = 1'b1;
        @(negedge clk);
        scan_req = 1'b0;
        k = 0;
        while (!done && k < 100) begin @(negedge clk); k++; end
        if (!done) chk("mid_reset_done_timeout", 32'd0, 32'd1);
        k = 0;
        while (!(busy1 && st1 == 32'h40) && k < 300) begin @(negedge clk); k++; end
        chk("mid_reset_at_0x40", st1, 32'h40);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midreset");
        chk("midreset_start_user", st1, 32'h33);
        reset = 1'b0;
        run_scan(22'd200, 16'h00FF, 22'd200 + 22'hA5, 1'b0);

`ifdef SCAN_TIMEOUT_EN
        // range unit never completes: WAIT expires after 1000 cycles
        never_done = 1'b1;
        push_launch(22'd5);
        base     = 22'd5;
        scan_req = 1'b1;
        @(negedge clk);
        scan_req = 1'b0;
        k = 0;
        while (busy1 && k < 1200) begin @(negedge clk); k++; end
        chk("tmo_cycles", 32'(k), 32'd1001);
        chk("tmo_error_l1", 32'(err1), 32'd1);
        chk("tmo_error_l3", 32'(err3), 32'd1);
        chk("tmo_rv", 32'(rv1), 32'd0);
        never_done = 1'b0;
        run_scan(22'd50, 16'h00FF, 22'd50 + 22'hA5, 1'b0);
        chk("tmo_error_cleared", 32'(err1), 32'd0);
`endif

        repeat (5) @(negedge clk);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q3_drained", 32'(q3.size()), 32'd0);
        chk("lq1_drained", 32'(lq1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
